imem_fetch_ctrl: RTL

Instruction-fetch sequencer for the 5-stage MIPS core. Owns the program counter, drives the 128-word combinational InstructionMemory, and loads the IF/ID pipeline register. Accepts stall requests from the hazard unit and redirect (branch/jump/jr) requests from later stages. Provides start, halt and fault status to the top level.

---
 rtl/imem_fetch_ctrl_if.sv | 27 ++
 rtl/imem_fetch_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-controller bus: control inputs, InstructionMemory port, IF/ID register and status outputs.
// master = fetch controller, slave = surrounding core / memory / bench.
interface imem_fetch_ctrl_if;
  logic        start;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pcplus4;
  logic        ifid_valid;
  logic [31:0] pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  modport master (
    input  start, stall, redirect, redirect_pc, imem_instr,
    output imem_addr, ifid_instr, ifid_pcplus4, ifid_valid, pc, halted, fault, fetch_count
  );

  modport slave (
    output start, stall, redirect, redirect_pc, imem_instr,
    input  imem_addr, ifid_instr, ifid_pcplus4, ifid_valid, pc, halted, fault, fetch_count
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// PC / IF-ID sequencer for a zero-latency instruction memory; one fetch per edge, stall holds everything.
// Redirect beats stall; optional jump-to-self halt detection under IMEM_HALT_DETECT_EN.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128
) (
  input  logic          clk,
  input  logic          rst,
  imem_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;

  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS) << 2;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pcplus4;
  logic        ifid_valid;
  logic        fault;
  logic [31:0] fetch_count;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

`ifdef IMEM_HALT_DETECT_EN
  logic halted;
  logic self_jump;

  // "j" whose absolute target equals its own address
  assign self_jump = (bus.imem_instr[31:26] == 6'b000010) &&
                     ({pc[31:28], bus.imem_instr[25:0], 2'b00} == pc);
  assign bus.halted = halted;
`else
  assign bus.halted = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      ifid_instr   <= 32'h0;
      ifid_pcplus4 <= 32'h0;
      ifid_valid   <= 1'b0;
      fault        <= 1'b0;
      fetch_count  <= 32'h0;
`ifdef IMEM_HALT_DETECT_EN
      halted       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ifid_instr   <= 32'h0;
          ifid_pcplus4 <= 32'h0;
          ifid_valid   <= 1'b0;
          if (bus.start) state <= RUN;
        end
        RUN: begin
          if (bus.redirect) begin
            ifid_instr   <= 32'h0;
            ifid_pcplus4 <= 32'h0;
            ifid_valid   <= 1'b0;
            if (bus.redirect_pc[1:0] != 2'b00) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              pc <= bus.redirect_pc;
            end
          end else if (!bus.stall) begin
            if (pc >= IMEM_BYTES) begin
              state        <= FAULT;
              fault        <= 1'b1;
              ifid_instr   <= 32'h0;
              ifid_pcplus4 <= 32'h0;
              ifid_valid   <= 1'b0;
            end else begin
              ifid_instr   <= bus.imem_instr;
              ifid_pcplus4 <= pc_plus4;
              ifid_valid   <= 1'b1;
              fetch_count  <= fetch_count + 32'd1;
`ifdef IMEM_HALT_DETECT_EN
              // the self-jump itself still goes down the pipe; PC parks on it
              if (self_jump) begin
                state  <= HALT;
                halted <= 1'b1;
              end else begin
                pc <= pc_plus4;
              end
`else
              pc <= pc_plus4;
`endif
            end
          end
        end
        HALT, FAULT: begin
          ifid_instr   <= 32'h0;
          ifid_pcplus4 <= 32'h0;
          ifid_valid   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.imem_addr    = pc;
  assign bus.pc           = pc;
  assign bus.ifid_instr   = ifid_instr;
  assign bus.ifid_pcplus4 = ifid_pcplus4;
  assign bus.ifid_valid   = ifid_valid;
  assign bus.fault        = fault;
  assign bus.fetch_count  = fetch_count;

endmodule
